// File: rtl/frame_sync_ctrl.sv
// Frame alignment controller: hunts for the FAS pair, confirms lock and forwards whole frames to the demapper.
// Optional CRC error counter is built only when FRAME_SYNC_CRC_CNT_EN is defined.
module frame_sync_ctrl #(
    parameter int         ROWS       = 4,
    parameter int         COLS       = 1024,
    parameter logic [7:0] FAS0       = 8'hF6,
    parameter logic [7:0] FAS1       = 8'h28,
    parameter int         LOCK_CNT   = 2,
    parameter int         UNLOCK_CNT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    input  logic        i_crc_err,
    input  logic        i_cnt_clr,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_data_valid,
    output logic        o_frame_data_fas,
    output logic        o_locked,
    output logic [1:0]  o_state,
    output logic        o_lof,
    output logic [15:0] o_crc_err_cnt
);
    // state   | meaning
    // HUNT    | searching for FAS0 followed by FAS1 at any byte offset
    // PRESYNC | candidate alignment, counting consecutive good FAS frames
    // SYNC    | locked, counting consecutive FAS misses
    localparam int               FRAME_LEN = ROWS * COLS;
    localparam int               POS_W     = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_LEN - 1);
    localparam logic [7:0]       LOCK_L    = 8'(LOCK_CNT);
    localparam logic [7:0]       UNLOCK_L  = 8'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic [7:0]       good_cnt, good_nxt;
    logic [7:0]       miss_cnt, miss_nxt;
    logic [7:0]       prev, prev_nxt;
    logic             fas0_ok, fas0_ok_nxt;
    logic             fwd, fwd_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             valid_q, valid_nxt;
    logic             fas_q, fas_nxt;
    logic             lof_q, lof_nxt;
    logic             fwd_now;
    logic             frame_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= HUNT;
            pos      <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
            prev     <= '0;
            fas0_ok  <= 1'b0;
            fwd      <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            fas_q    <= 1'b0;
            lof_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            good_cnt <= good_nxt;
            miss_cnt <= miss_nxt;
            prev     <= prev_nxt;
            fas0_ok  <= fas0_ok_nxt;
            fwd      <= fwd_nxt;
            data_q   <= data_nxt;
            valid_q  <= valid_nxt;
            fas_q    <= fas_nxt;
            lof_q    <= lof_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pos_nxt     = pos;
        good_nxt    = good_cnt;
        miss_nxt    = miss_cnt;
        prev_nxt    = prev;
        fas0_ok_nxt = fas0_ok;
        fwd_nxt     = fwd;
        data_nxt    = data_q;
        valid_nxt   = 1'b0;
        fas_nxt     = 1'b0;
        lof_nxt     = 1'b0;
        fwd_now     = 1'b0;
        frame_ok    = 1'b0;
        if (i_frame_data_valid) begin
            prev_nxt = i_frame_data;
            pos_nxt  = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            fwd_now  = fwd || (state == SYNC && pos == '0);
            frame_ok = fas0_ok && (i_frame_data == FAS1);
            if (fwd_now) begin
                data_nxt  = i_frame_data;
                valid_nxt = 1'b1;
                fas_nxt   = (pos == '0);
            end
            if (state != HUNT && pos == '0) begin
                fas0_ok_nxt = (i_frame_data == FAS0);
            end
            unique case (state)
                HUNT: begin
                    if (prev == FAS0 && i_frame_data == FAS1) begin
                        pos_nxt  = POS_W'(2);
                        good_nxt = 8'd1;
                        if (LOCK_CNT == 1) state_nxt = SYNC;
                        else               state_nxt = PRESYNC;
                    end
                end
                PRESYNC: begin
                    if (pos == POS_W'(1)) begin
                        if (frame_ok) begin
                            good_nxt = good_cnt + 8'd1;
                            if (good_nxt >= LOCK_L) state_nxt = SYNC;
                        end else begin
                            good_nxt  = '0;
                            state_nxt = HUNT;
                        end
                    end
                end
                SYNC: begin
                    if (pos == POS_W'(1)) begin
                        if (frame_ok) begin
                            miss_nxt = '0;
                        end else begin
                            miss_nxt = miss_cnt + 8'd1;
                            if (miss_nxt >= UNLOCK_L) begin
                                state_nxt = HUNT;
                                lof_nxt   = 1'b1;
                                miss_nxt  = '0;
                                good_nxt  = '0;
                            end
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
            // the deciding byte of a loss of lock is still forwarded above; only later bytes are cut
            if (fwd_now) fwd_nxt = 1'b1;
            if (state == SYNC && state_nxt != SYNC) fwd_nxt = 1'b0;
        end
    end

    assign o_frame_data       = data_q;
    assign o_frame_data_valid = valid_q;
    assign o_frame_data_fas   = fas_q;
    assign o_lof              = lof_q;
    assign o_state            = state;
    assign o_locked           = (state == SYNC);

`ifdef FRAME_SYNC_CRC_CNT_EN
    logic [15:0] crc_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            crc_cnt <= '0;
        end else if (i_crc_err && fwd && crc_cnt != 16'hFFFF) begin
            crc_cnt <= crc_cnt + 16'd1;
        end
    end

    assign o_crc_err_cnt = crc_cnt;
`else
    logic unused_crc;
    assign unused_crc    = i_crc_err ^ i_cnt_clr;
    assign o_crc_err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: hand-written vector table, directed corner sequences and random frames vs a reference model.
`timescale 1ns/1ps
module tb_frame_sync_ctrl;
    localparam int         ROWS    = 4;
    localparam int         COLS    = 8;
    localparam int         FL      = ROWS * COLS;
    localparam logic [7:0] F0      = 8'hF6;
    localparam logic [7:0] F1      = 8'h28;
    localparam int         LOCKN   = 2;
    localparam int         UNLOCKN = 4;
`ifdef FRAME_SYNC_CRC_CNT_EN
    localparam int CRC_ON = 1;
`else
    localparam int CRC_ON = 0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_frame_data = 8'h00;
    logic        i_frame_data_valid = 1'b0;
    logic        i_crc_err = 1'b0;
    logic        i_cnt_clr = 1'b0;
    logic [7:0]  o_frame_data;
    logic        o_frame_data_valid;
    logic        o_frame_data_fas;
    logic        o_locked;
    logic [1:0]  o_state;
    logic        o_lof;
    logic [15:0] o_crc_err_cnt;

    frame_sync_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .FAS0(F0), .FAS1(F1),
        .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_frame_data(i_frame_data), .i_frame_data_valid(i_frame_data_valid),
        .i_crc_err(i_crc_err), .i_cnt_clr(i_cnt_clr),
        .o_frame_data(o_frame_data), .o_frame_data_valid(o_frame_data_valid),
        .o_frame_data_fas(o_frame_data_fas), .o_locked(o_locked),
        .o_state(o_state), .o_lof(o_lof), .o_crc_err_cnt(o_crc_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    bit saw_valid;
    bit saw_lof;
    int fwd_count;

    // reference model: alignment kept as the absolute index of a frame start in the accepted-byte history
    logic [7:0] hist[$];
    int         m_state, m_fs, m_good, m_miss, e_crc;
    bit         m_fwd, e_valid, e_fas, e_lof;
    logic [7:0] e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_state = 0; m_fs = 0; m_good = 0; m_miss = 0; m_fwd = 0;
        e_valid = 0; e_fas = 0; e_lof = 0; e_data = 8'h00; e_crc = 0;
    endtask

    task automatic model_step(input bit rst, input logic [7:0] d, input bit v, input bit crc, input bit clr);
        if (rst) begin
            model_reset();
            return;
        end
        e_valid = 0; e_fas = 0; e_lof = 0;
        if (CRC_ON != 0) begin
            if (clr) e_crc = 0;
            else if (crc && m_fwd && e_crc < 65535) e_crc++;
        end
        if (v) begin
            int         n = hist.size();
            int         rel = ((n - m_fs) % FL + FL) % FL;
            int         old = m_state;
            bit         fwd_now = m_fwd || (m_state == 2 && rel == 0);
            logic [7:0] prv = (n > 0) ? hist[n-1] : 8'h00;
            if (fwd_now) begin
                e_valid = 1; e_data = d; e_fas = (rel == 0);
            end
            if (m_state == 0) begin
                if (prv == F0 && d == F1) begin
                    m_fs = n - 1; m_good = 1;
                    m_state = (LOCKN == 1) ? 2 : 1;
                end
            end else if (rel == 1) begin
                bit ok = (prv == F0) && (d == F1);
                if (m_state == 1) begin
                    if (ok) begin
                        m_good++;
                        if (m_good >= LOCKN) m_state = 2;
                    end else begin
                        m_good = 0; m_state = 0;
                    end
                end else begin
                    m_miss = ok ? 0 : m_miss + 1;
                    if (m_miss >= UNLOCKN) begin
                        m_state = 0; e_lof = 1; m_miss = 0;
                    end
                end
            end
            if (old == 2 && m_state != 2) m_fwd = 0;
            else if (fwd_now) m_fwd = 1;
            hist.push_back(d);
        end
    endtask

    function automatic logic [29:0] dut_pack();
        return {o_state, o_locked, o_frame_data_valid, o_frame_data_fas, o_lof, o_frame_data, o_crc_err_cnt};
    endfunction

    function automatic logic [29:0] exp_pack();
        return {2'(m_state), (m_state == 2), e_valid, e_fas, e_lof, e_data, 16'(e_crc)};
    endfunction

    task automatic step(input bit rst, input logic [7:0] d, input bit v, input bit crc, input bit clr, input bit do_chk);
        i_rst = rst; i_frame_data = d; i_frame_data_valid = v; i_crc_err = crc; i_cnt_clr = clr;
        model_step(rst, d, v, crc, clr);
        @(posedge i_clk);
        #1;
        if (o_frame_data_valid) begin
            saw_valid = 1;
            fwd_count++;
        end
        if (o_lof) saw_lof = 1;
        if (do_chk) chk("model", 32'(dut_pack()), 32'(exp_pack()));
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input int gapmax,
                              input int crc_at, input bit clr_at0);
        for (int p = 0; p < FL; p++) begin
            logic [7:0] d;
            if (gapmax > 0 && $urandom_range(0, 3) == 0) begin
                int g = int'($urandom_range(1, gapmax));
                repeat (g) step(0, 8'($urandom), 0, 0, 0, 1);
            end
            d = (p == 0) ? b0 : (p == 1) ? b1 : 8'($urandom & 32'h7F);
            step(0, d, 1, p == crc_at, clr_at0 && p == 0, 1);
        end
    endtask

    task automatic acquire();
        step(1, 8'h00, 0, 0, 0, 1);
        repeat (4) step(0, 8'h00, 1, 0, 0, 1);
        repeat (3) send_frame(F0, F1, 0, -1, 0);
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] d;
        bit         v;
        int         rep;
        logic [1:0] st;
        bit         ov;
        bit         of;
        bit         lof;
        logic [7:0] od;
    } vec_t;
    vec_t vt[$];

    function automatic void add(bit rst, logic [7:0] d, bit v, int rep, logic [1:0] st,
                                bit ov, bit of, bit lof, logic [7:0] od);
        vec_t x;
        x.rst = rst; x.d = d; x.v = v; x.rep = rep; x.st = st;
        x.ov = ov; x.of = of; x.lof = lof; x.od = od;
        vt.push_back(x);
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        model_reset();
        // clean acquisition, forwarding, valid gap, then loss of frame after 4 bad FAS1 bytes
        add(1, 8'h00, 0,  2, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1,  3, 0, 0, 0, 0, 8'h00);
        add(0, 8'hF6, 1,  1, 0, 0, 0, 0, 8'h00);
        add(0, 8'hF6, 1,  1, 0, 0, 0, 0, 8'h00);
        add(0, 8'h28, 1,  1, 1, 0, 0, 0, 8'h00);
        add(0, 8'h55, 1, 30, 1, 0, 0, 0, 8'h00);
        add(0, 8'hF6, 1,  1, 1, 0, 0, 0, 8'h00);
        add(0, 8'h28, 1,  1, 2, 0, 0, 0, 8'h00);
        add(0, 8'h55, 1, 30, 2, 0, 0, 0, 8'h00);
        add(0, 8'hF6, 1,  1, 2, 1, 1, 0, 8'hF6);
        add(0, 8'h28, 1,  1, 2, 1, 0, 0, 8'h28);
        add(0, 8'h77, 0,  3, 2, 0, 0, 0, 8'h28);
        add(0, 8'h11, 1, 30, 2, 1, 0, 0, 8'h11);
        for (int k = 1; k <= 4; k++) begin
            add(0, 8'hF6, 1, 1, 2, 1, 1, 0, 8'hF6);
            add(0, 8'h29, 1, 1, (k == 4) ? 2'd0 : 2'd2, 1, 0, k == 4, 8'h29);
            if (k < 4) add(0, 8'h11, 1, 30, 2, 1, 0, 0, 8'h11);
        end
        add(0, 8'h11, 1, 1, 0, 0, 0, 0, 8'h29);

        foreach (vt[i]) begin
            for (int r = 0; r < vt[i].rep; r++) step(vt[i].rst, vt[i].d, vt[i].v, 0, 0, 1);
            chk($sformatf("vec%0d", i),
                32'({o_state, o_locked, o_frame_data_valid, o_frame_data_fas, o_lof, o_frame_data}),
                32'({vt[i].st, vt[i].st == 2'd2, vt[i].ov, vt[i].of, vt[i].lof, vt[i].od}));
        end

        // false lock: one embedded FAS pair with no FAS a frame later
        step(1, 8'h00, 0, 0, 0, 1);
        saw_valid = 0;
        repeat (5) step(0, 8'h00, 1, 0, 0, 1);
        step(0, F0, 1, 0, 0, 1);
        step(0, F1, 1, 0, 0, 1);
        chk("false_lock_presync", 32'(o_state), 32'd1);
        repeat (30) step(0, 8'($urandom & 32'h7F), 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("false_lock_hunt", 32'(o_state), 32'd0);
        repeat (20) step(0, 8'($urandom & 32'h7F), 1, 0, 0, 1);
        chk("false_lock_no_valid", 32'(saw_valid), 32'd0);

        // three bad frames then a good one keep lock; miss count restarts
        acquire();
        saw_lof = 0;
        repeat (3) send_frame(F0, 8'h29, 0, -1, 0);
        send_frame(F0, F1, 0, -1, 0);
        repeat (3) send_frame(F0, 8'h29, 0, -1, 0);
        chk("three_bad_locked", 32'(o_locked), 32'd1);
        chk("three_bad_no_lof", 32'(saw_lof), 32'd0);

        // valid gaps while locked
        send_frame(F0, F1, 0, -1, 0);
        fwd_count = 0;
        repeat (4) send_frame(F0, F1, 5, -1, 0);
        chk("gaps_fwd_count", 32'(fwd_count), 32'(4 * FL));
        chk("gaps_locked", 32'(o_locked), 32'd1);

        // reset in the middle of a forwarded frame
        step(0, F0, 1, 0, 0, 1);
        repeat (9) step(0, 8'($urandom), 1, 0, 0, 1);
        step(1, 8'($urandom), 1, 0, 0, 1);
        chk("reset_midframe", 32'(dut_pack()), 32'd0);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("after_reset", 32'(dut_pack()), 32'd0);

        // CRC counter: pulses in SYNC, one on the loss-of-lock byte, one in HUNT, then clear with pulse
        acquire();
        send_frame(F0, F1, 0, 5, 0);
        send_frame(F0, F1, 0, 10, 0);
        send_frame(F0, F1, 0, 20, 0);
        chk("crc_three", 32'(o_crc_err_cnt), 32'(3 * CRC_ON));
        repeat (3) send_frame(F0, 8'h29, 0, -1, 0);
        saw_lof = 0;
        send_frame(F0, 8'h29, 0, 1, 0);
        chk("lof_seen", 32'(saw_lof), 32'd1);
        chk("lof_unlocked", 32'(o_locked), 32'd0);
        chk("crc_on_lof", 32'(o_crc_err_cnt), 32'(4 * CRC_ON));
        step(0, 8'h00, 0, 1, 0, 1);
        chk("crc_hunt_ignored", 32'(o_crc_err_cnt), 32'(4 * CRC_ON));
        step(0, 8'h00, 0, 1, 1, 1);
        chk("crc_clear_wins", 32'(o_crc_err_cnt), 32'd0);

`ifdef FRAME_SYNC_CRC_CNT_EN
        acquire();
        repeat (65535) step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 1);
        chk("crc_saturate", 32'(o_crc_err_cnt), 32'h0000FFFF);
`endif

        // random frames: occasional FAS corruption, slips, gaps, CRC pulses and clears
        step(1, 8'h00, 0, 0, 0, 1);
        repeat (3) step(0, 8'h00, 1, 0, 0, 1);
        for (int f = 0; f < 80; f++) begin
            logic [7:0] b0;
            logic [7:0] b1;
            b0 = ($urandom_range(0, 9) == 0) ? 8'($urandom) : F0;
            b1 = ($urandom_range(0, 9) == 0) ? 8'($urandom) : F1;
            if ($urandom_range(0, 19) == 0) begin
                int s = int'($urandom_range(1, 3));
                repeat (s) step(0, 8'($urandom), 1, 0, 0, 1);
            end
            send_frame(b0, b1, int'($urandom_range(0, 1)) * 3, int'($urandom_range(0, 40)),
                       $urandom_range(0, 30) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
